// File: rtl/led_breathe_pwm_pkg.sv
// ---------------------------------------------------------------------------
// led_breathe_pwm_pkg
//   Shared definitions for the LED breathing output stage: the FSM state
//   encoding, which is also driven out on state_o, and a helper that sizes
//   the step prescaler counter.
// ---------------------------------------------------------------------------
package led_breathe_pwm_pkg;

  localparam int unsigned STATE_W = 3;

  // Encodings are visible on state_o, so they are fixed explicitly.
  // Codes 5..7 are unused and recover to ST_IDLE.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_e;

  // The prescaler counts 0..n-1. It needs clog2(n) bits, and never fewer
  // than one bit, so that n == 1 still yields a legal vector.
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_breathe_pwm_pwm_core.sv
// ---------------------------------------------------------------------------
// pwm_core
//   Free-running PWM generator. The counter runs 0..2**PWM_BITS-1 and wraps.
//   The requested duty is copied into a shadow register only on the last
//   count of each PWM window, so a duty change never produces a runt pulse.
//   A clear input forces the shadow to zero immediately so the LED goes dark
//   without waiting for the window to end.
// Ports
//   clk     in   1         clock, rising edge
//   rst_n   in   1         asynchronous active-low reset
//   duty    in   PWM_BITS  requested duty (0 = dark, all ones = max)
//   clr     in   1         force shadow duty to zero on the next edge
//   led_on  out  1         combinational PWM level (1 = lit)
// ---------------------------------------------------------------------------
module pwm_core #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                clr,
  output logic                led_on
);

  localparam logic [PWM_BITS-1:0] CNT_LAST = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] pwmCnt_q;
  logic [PWM_BITS-1:0] dutySh_q;

  // The window counter simply wraps from all ones back to zero, which is
  // exactly the 0..DMAX free-running sequence we want.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwmCnt_q <= '0;
    end else begin
      pwmCnt_q <= pwmCnt_q + 1'b1;
    end
  end

  // The shadow duty follows the requested duty only at the window boundary.
  // The clear input takes priority so that a disable blanks the LED at once
  // rather than finishing the current window at the old brightness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dutySh_q <= '0;
    end else if (clr) begin
      dutySh_q <= '0;
    end else if (pwmCnt_q == CNT_LAST) begin
      dutySh_q <= duty;
    end
  end

  // A strict less-than makes duty 0 fully dark and duty DMAX lit for DMAX
  // out of every 2**PWM_BITS cycles.
  assign led_on = (pwmCnt_q < dutySh_q);

endmodule

// File: rtl/led_breathe_pwm.sv
// ---------------------------------------------------------------------------
// led_breathe_pwm
//   Output stage for the active-low user LED. In breathe mode the LED
//   brightness ramps up, holds, ramps down, holds and repeats. In blink mode
//   the pin simply follows blink_in, one cycle later. The breathing FSM keeps
//   running in blink mode, so returning to breathe mode resumes mid-breath.
// Ports
//   USER_CLK          in   1         clock, rising edge
//   FPGA_CPU_RESET_B  in   1         asynchronous active-low reset
//   enable            in   1         1 = run the breathe FSM, 0 = idle and dark
//   mode              in   1         0 = breathe PWM, 1 = blink_in pass-through
//   blink_in          in   1         LED-on level from the blink logic
//   GPIO_LED_N        out  1         registered LED pin, active low
//   duty_o            out  PWM_BITS  current duty register
//   state_o           out  3         FSM state encoding
// ---------------------------------------------------------------------------
module led_breathe_pwm
  import led_breathe_pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned STEP_DIV   = 4096,
  parameter int unsigned HOLD_STEPS = 64
) (
  input  logic                USER_CLK,
  input  logic                FPGA_CPU_RESET_B,
  input  logic                enable,
  input  logic                mode,
  input  logic                blink_in,
  output logic                GPIO_LED_N,
  output logic [PWM_BITS-1:0] duty_o,
  output logic [STATE_W-1:0]  state_o
);

  localparam int unsigned PRE_W  = cntWidth(STEP_DIV);
  localparam int unsigned HOLD_W = $clog2(HOLD_STEPS + 1);

  localparam logic [PWM_BITS-1:0] DMAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PRE_W-1:0]    preCnt_q, preCnt_d;
  logic [HOLD_W-1:0]   holdCnt_q, holdCnt_d;
  logic                ledN_q;
  logic                stepTick;
  logic                ledOn;

  // The prescaler is held at zero in IDLE, so one brightness step takes
  // exactly STEP_DIV cycles from the moment the FSM starts.
  assign stepTick = (state_q != ST_IDLE) && (preCnt_q == PRE_LAST);

  // Next-state logic. The duty never wraps: the ramps end by leaving the
  // state on the step that reaches DMAX or zero. A low enable overrides
  // everything, including a step tick in the same cycle. Any state change
  // restarts both the prescaler and the hold counter, so every state begins
  // with a full step period.
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    holdCnt_d = holdCnt_q;
    preCnt_d  = (state_q == ST_IDLE || stepTick) ? '0 : preCnt_q + 1'b1;

    if (!enable) begin
      state_d = ST_IDLE;
      duty_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_d  = '0;
          state_d = ST_RISE;
        end
        ST_RISE: begin
          if (stepTick) begin
            duty_d = duty_q + 1'b1;
            if (duty_q == DMAX - 1'b1) begin
              state_d = ST_HOLD_HI;
            end
          end
        end
        ST_HOLD_HI, ST_HOLD_LO: begin
          if (stepTick) begin
            if (holdCnt_q == HOLD_LAST) begin
              state_d = (state_q == ST_HOLD_HI) ? ST_FALL : ST_RISE;
            end else begin
              holdCnt_d = holdCnt_q + 1'b1;
            end
          end
        end
        ST_FALL: begin
          if (stepTick) begin
            duty_d = duty_q - 1'b1;
            if (duty_q == DUTY_ONE) begin
              state_d = ST_HOLD_LO;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
        end
      endcase
    end

    if (state_d != state_q) begin
      preCnt_d  = '0;
      holdCnt_d = '0;
    end
  end

  // FSM, duty and counter registers.
  always_ff @(posedge USER_CLK or negedge FPGA_CPU_RESET_B) begin
    if (!FPGA_CPU_RESET_B) begin
      state_q   <= ST_IDLE;
      duty_q    <= '0;
      preCnt_q  <= '0;
      holdCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      preCnt_q  <= preCnt_d;
      holdCnt_q <= holdCnt_d;
    end
  end

  // The shadow duty is cleared whenever enable is low, so the LED is dark
  // within two cycles of a disable instead of finishing its PWM window.
  pwm_core #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_core (
    .clk    (USER_CLK),
    .rst_n  (FPGA_CPU_RESET_B),
    .duty   (duty_q),
    .clr    (~enable),
    .led_on (ledOn)
  );

  // The pin is registered so that it is glitch-free. The pin is active low,
  // which is why both sources are inverted. Gating with enable keeps the LED
  // dark on the very first disabled edge.
  always_ff @(posedge USER_CLK or negedge FPGA_CPU_RESET_B) begin
    if (!FPGA_CPU_RESET_B) begin
      ledN_q <= 1'b1;
    end else begin
      ledN_q <= mode ? ~blink_in : ~(ledOn & enable);
    end
  end

  assign GPIO_LED_N = ledN_q;
  assign duty_o     = duty_q;
  assign state_o    = state_q;

endmodule
